snn_core_sequencer: RTL and testbench

Bus initiator that drives the 9-bit address/strobe interface of one SNN core, consumed by the core's address decoder. For each picture it selects the weight bank, streams input spike events as broadcast spike accesses, then issues the done-picture access. In idle it also forwards single configuration writes into the slice region. It sits between the input spike source / host control and the core.

---
 rtl/snn_core_sequencer.sv | 115 +++++++++++
 tb/tb_snn_core_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snn_core_sequencer.sv
// Drives one SNN core's address/strobe bus. Each picture issues a weight-select access,
// then one broadcast access per input spike, then a done access. Idle cycles forward config writes.
module snn_core_sequencer #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 16,
  parameter int DONE_PIC_ADDR = 448,
  parameter int WSEL1_ADDR    = 464,
  parameter int WSEL0_ADDR    = 449,
  parameter int SPIKE_GAP     = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              weight_sel_i,
  input  logic              spike_valid_i,
  input  logic [7:0]        spike_axon_i,
  input  logic              spike_last_i,
  output logic              spike_ready_o,
  input  logic              cfg_valid_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic              cfg_ready_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              we_o,
  output logic              en_o,
  output logic              busy_o,
  output logic              pic_done_o,
  output logic              cfg_err_o,
  output logic [15:0]       spike_count_o
);
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {IDLE, WSEL, SPIKE, GAP, DONE} state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             spike_fire;
  logic             cfg_fire;
  logic             cfg_ctrl;

  // The weight-select access is on the bus while in WSEL, so spikes are already taken there;
  // this keeps the first spike access right behind the weight-select access.
  assign spike_ready_o = !rst_i && (state == WSEL || state == SPIKE);
  assign cfg_ready_o   = !rst_i && state == IDLE && !start_i;
  assign spike_fire    = spike_valid_i && spike_ready_o;
  assign cfg_fire      = cfg_valid_i && cfg_ready_o;
  assign cfg_ctrl      = cfg_addr_i[ADDR_W-1 -: 3] == 3'b111;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      addr_o        <= '0;
      data_o        <= '0;
      we_o          <= 1'b0;
      en_o          <= 1'b0;
      busy_o        <= 1'b0;
      pic_done_o    <= 1'b0;
      cfg_err_o     <= 1'b0;
      spike_count_o <= '0;
    end else begin
      en_o       <= 1'b0;
      we_o       <= 1'b0;
      pic_done_o <= 1'b0;
      cfg_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= WSEL;
            busy_o        <= 1'b1;
            spike_count_o <= '0;
            en_o          <= 1'b1;
            addr_o        <= weight_sel_i ? ADDR_W'(WSEL1_ADDR) : ADDR_W'(WSEL0_ADDR);
          end else if (cfg_fire) begin
            if (cfg_ctrl) begin
              cfg_err_o <= 1'b1;
            end else begin
              en_o   <= 1'b1;
              we_o   <= 1'b1;
              addr_o <= cfg_addr_i;
              data_o <= cfg_data_i;
            end
          end
        end
        WSEL, SPIKE: begin
          state <= SPIKE;
          if (spike_fire) begin
            en_o   <= 1'b1;
            addr_o <= {{(ADDR_W-8){1'b0}}, spike_axon_i};
            if (spike_count_o != 16'hFFFF) spike_count_o <= spike_count_o + 16'd1;
            if (spike_last_i) begin
              state <= DONE;
            end else if (SPIKE_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(SPIKE_GAP - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= SPIKE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          busy_o     <= 1'b0;
          en_o       <= 1'b1;
          pic_done_o <= 1'b1;
          addr_o     <= ADDR_W'(DONE_PIC_ADDR);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_core_sequencer.sv
// Scoreboard bench: dut 0 runs with no spike gap, dut 1 with a 2-cycle gap.
module tb_snn_core_sequencer;
  typedef struct packed {
    logic [8:0]  addr;
    logic        we;
    logic [15:0] data;
    logic        done;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st[2], wsel[2], sv[2], slast[2], srdy[2], cv[2], crdy[2];
  logic        we[2], en[2], busy[2], pd[2], cerr[2];
  logic [7:0]  sax[2];
  logic [8:0]  ca[2], addr[2];
  logic [15:0] cd[2], data[2], cnt[2];

  acc_t q[2][$];
  int   tq[2][$];
  int   ndone[2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  acc_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snn_core_sequencer #(.SPIKE_GAP(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(st[0]), .weight_sel_i(wsel[0]),
    .spike_valid_i(sv[0]), .spike_axon_i(sax[0]), .spike_last_i(slast[0]), .spike_ready_o(srdy[0]),
    .cfg_valid_i(cv[0]), .cfg_addr_i(ca[0]), .cfg_data_i(cd[0]), .cfg_ready_o(crdy[0]),
    .addr_o(addr[0]), .data_o(data[0]), .we_o(we[0]), .en_o(en[0]), .busy_o(busy[0]),
    .pic_done_o(pd[0]), .cfg_err_o(cerr[0]), .spike_count_o(cnt[0]));

  snn_core_sequencer #(.SPIKE_GAP(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st[1]), .weight_sel_i(wsel[1]),
    .spike_valid_i(sv[1]), .spike_axon_i(sax[1]), .spike_last_i(slast[1]), .spike_ready_o(srdy[1]),
    .cfg_valid_i(cv[1]), .cfg_addr_i(ca[1]), .cfg_data_i(cd[1]), .cfg_ready_o(crdy[1]),
    .addr_o(addr[1]), .data_o(data[1]), .we_o(we[1]), .en_o(en[1]), .busy_o(busy[1]),
    .pic_done_o(pd[1]), .cfg_err_o(cerr[1]), .spike_count_o(cnt[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every bus access is matched against the scoreboard in order.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en[i] === 1'b1) begin
        tq[i].push_back(cyc);
        if (q[i].size() == 0) begin
          chk($sformatf("unexpected_access%0d", i), {23'd0, addr[i]}, 32'h1FF);
        end else begin
          me = q[i].pop_front();
          chk($sformatf("addr%0d", i), {23'd0, addr[i]}, {23'd0, me.addr});
          chk($sformatf("we%0d", i), {31'd0, we[i]}, {31'd0, me.we});
          if (me.we) chk($sformatf("data%0d", i), {16'd0, data[i]}, {16'd0, me.data});
          chk($sformatf("pic_done%0d", i), {31'd0, pd[i]}, {31'd0, me.done});
          if (pd[i] === 1'b1) ndone[i]++;
        end
      end else if (!rst) begin
        chk($sformatf("done_without_access%0d", i), {31'd0, pd[i]}, 32'd0);
      end
    end
  end

  task automatic go(input int i, input logic ws);
    st[i] = 1'b1; wsel[i] = ws;
    @(negedge clk);
    chk("start_idle", {31'd0, busy[i]}, 32'd0);
    q[i].push_back('{addr: ws ? 9'd464 : 9'd449, we: 1'b0, data: 16'd0, done: 1'b0});
    @(posedge clk); #1;
    st[i] = 1'b0;
  endtask

  task automatic spk(input int i, input logic [7:0] ax, input logic last, output int waits);
    logic got;
    sv[i] = 1'b1; sax[i] = ax; slast[i] = last; waits = 0; got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (srdy[i]) begin got = 1'b1; break; end
      waits++;
    end
    chk("spike_accept", {31'd0, got}, 32'd1);
    if (got) begin
      q[i].push_back('{addr: {1'b0, ax}, we: 1'b0, data: 16'd0, done: 1'b0});
      if (last) q[i].push_back('{addr: 9'd448, we: 1'b0, data: 16'd0, done: 1'b1});
    end
    @(posedge clk); #1;
    if (last) sv[i] = 1'b0;
  endtask

  task automatic cfg(input int i, input logic [8:0] a, input logic [15:0] d);
    logic got;
    cv[i] = 1'b1; ca[i] = a; cd[i] = d; got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (crdy[i]) begin got = 1'b1; break; end
    end
    chk("cfg_accept", {31'd0, got}, 32'd1);
    if (got && a[8:6] != 3'b111) q[i].push_back('{addr: a, we: 1'b1, data: d, done: 1'b0});
    @(posedge clk); #1;
    cv[i] = 1'b0;
    if (a[8:6] == 3'b111) begin
      @(negedge clk); chk("cfg_err_pulse", {31'd0, cerr[i]}, 32'd1);
      @(negedge clk); chk("cfg_err_single", {31'd0, cerr[i]}, 32'd0);
    end
  endtask

  initial begin
    int w, d0;
    logic got;
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; wsel[i] = 0; sv[i] = 0; slast[i] = 0; sax[i] = 0;
      cv[i] = 0; ca[i] = 0; cd[i] = 0; ndone[i] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spike_ready", {31'd0, srdy[0]}, 32'd0);
    chk("rst_cfg_ready", {31'd0, crdy[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_en", {31'd0, en[0]}, 32'd0);
      chk("idle_en_b", {31'd0, en[1]}, 32'd0);
      chk("idle_addr", {23'd0, addr[0]}, 32'd0);
      chk("idle_data", {16'd0, data[0]}, 32'd0);
      chk("idle_we", {31'd0, we[0]}, 32'd0);
      chk("idle_busy", {31'd0, busy[0]}, 32'd0);
      chk("idle_err", {31'd0, cerr[0]}, 32'd0);
      chk("idle_count", {16'd0, cnt[0]}, 32'd0);
      chk("idle_spike_ready", {31'd0, srdy[0]}, 32'd0);
      chk("idle_cfg_ready", {31'd0, crdy[0]}, 32'd1);
    end
    @(posedge clk); #1;

    cfg(0, 9'd300, 16'hABCD);
    cfg(0, 9'd460, 16'h5555);

    // Back-to-back picture, no gap.
    @(posedge clk); #1;
    tq[0].delete();
    go(0, 1'b1);
    spk(0, 8'd5, 1'b0, w);
    spk(0, 8'd17, 1'b0, w);
    spk(0, 8'd255, 1'b1, w);
    repeat (3) @(posedge clk); #1;
    chk("pic_count", {16'd0, cnt[0]}, 32'd3);
    chk("pic_accesses", tq[0].size(), 32'd5);
    for (int k = 1; k < tq[0].size(); k++) chk("pic_back_to_back", tq[0][k] - tq[0][k-1], 32'd1);

    // Gapped picture on dut 1.
    tq[1].delete();
    go(1, 1'b0);
    spk(1, 8'd10, 1'b0, w);
    chk("gap_first_wait", w, 32'd0);
    spk(1, 8'd20, 1'b0, w);
    chk("gap_wait2", w, 32'd2);
    spk(1, 8'd30, 1'b1, w);
    chk("gap_wait3", w, 32'd2);
    repeat (3) @(posedge clk); #1;
    chk("gap_count", {16'd0, cnt[1]}, 32'd3);
    chk("gap_accesses", tq[1].size(), 32'd5);
    if (tq[1].size() == 5) begin
      chk("gap_wsel_to_spike", tq[1][1] - tq[1][0], 32'd1);
      chk("gap_spacing1", tq[1][2] - tq[1][1], 32'd3);
      chk("gap_spacing2", tq[1][3] - tq[1][2], 32'd3);
      chk("gap_last_to_done", tq[1][4] - tq[1][3], 32'd1);
    end

    // Start wins over a simultaneous config write; the write follows the done access.
    st[0] = 1'b1; wsel[0] = 1'b0; cv[0] = 1'b1; ca[0] = 9'd100; cd[0] = 16'h1234;
    @(negedge clk);
    chk("start_prio_cfg_ready", {31'd0, crdy[0]}, 32'd0);
    q[0].push_back('{addr: 9'd449, we: 1'b0, data: 16'd0, done: 1'b0});
    @(posedge clk); #1;
    st[0] = 1'b0;
    d0 = ndone[0];
    spk(0, 8'd7, 1'b1, w);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (crdy[0]) begin got = 1'b1; break; end
    end
    chk("stalled_cfg_accept", {31'd0, got}, 32'd1);
    if (got) q[0].push_back('{addr: 9'd100, we: 1'b1, data: 16'h1234, done: 1'b0});
    @(posedge clk); #1;
    cv[0] = 1'b0;
    chk("cfg_after_done", ndone[0] - d0, 32'd1);
    repeat (3) @(posedge clk); #1;
    chk("stalled_cfg_drained", q[0].size(), 32'd0);

    // Reset in the middle of a picture.
    go(0, 1'b1);
    spk(0, 8'd1, 1'b0, w);
    spk(0, 8'd2, 1'b0, w);
    sv[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_count_before_rst", {16'd0, cnt[0]}, 32'd2);
    chk("mid_rst_spike_ready", {31'd0, srdy[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("mid_rst_count", {16'd0, cnt[0]}, 32'd0);
    chk("mid_rst_en", {31'd0, en[0]}, 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", q[0].size(), 32'd0);
    chk("mid_rst_q1", q[1].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
